// File: rtl/reg_bus_arbiter.sv
// Round-robin scheduler sharing one AXI4-Lite slave between two requesters.
// One transaction in flight; per-phase wait timeout aborts a hung slave.
module reg_bus_arbiter #(
  parameter int AXI_DATA_WIDTH_P = 32,
  parameter int AXI_ADDR_WIDTH_P = 7,
  parameter int TIMEOUT_P        = 255
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [1:0]                      req_valid,
  output logic [1:0]                      req_ready,
  input  logic [1:0]                      req_write,
  input  logic [2*AXI_ADDR_WIDTH_P-1:0]   req_addr,
  input  logic [2*AXI_DATA_WIDTH_P-1:0]   req_wdata,
  input  logic [2*AXI_DATA_WIDTH_P/8-1:0] req_wstrb,
  output logic [1:0]                      rsp_valid,
  output logic [AXI_DATA_WIDTH_P-1:0]     rsp_rdata,
  output logic                            rsp_err,
  output logic [AXI_ADDR_WIDTH_P-1:0]     awaddr,
  output logic                            awvalid,
  input  logic                            awready,
  output logic [AXI_DATA_WIDTH_P-1:0]     wdata,
  output logic [AXI_DATA_WIDTH_P/8-1:0]   wstrb,
  output logic                            wvalid,
  input  logic                            wready,
  input  logic [1:0]                      bresp,
  input  logic                            bvalid,
  output logic                            bready,
  output logic [AXI_ADDR_WIDTH_P-1:0]     araddr,
  output logic                            arvalid,
  input  logic                            arready,
  input  logic [AXI_DATA_WIDTH_P-1:0]     rdata,
  input  logic [1:0]                      rresp,
  input  logic                            rvalid,
  output logic                            rready
);

  localparam int DW = AXI_DATA_WIDTH_P;
  localparam int AW = AXI_ADDR_WIDTH_P;
  localparam int SW = AXI_DATA_WIDTH_P / 8;
  localparam int CW = $clog2(TIMEOUT_P + 1);

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    WR_ADDR,
    WR_RESP,
    RD_ADDR,
    RD_DATA
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic            last_grant_q;
  logic            idx_q;
  logic            write_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [SW-1:0]   wstrb_q;
  logic [CW-1:0]   cnt_q;
  logic            aw_done_q;
  logic            w_done_q;
  logic [1:0]      rsp_valid_q;
  logic [DW-1:0]   rsp_rdata_q;
  logic            rsp_err_q;

  logic            gnt_vld;
  logic            gnt_idx;
  logic            timeout;
  logic            in_wait;
  logic            aw_hs;
  logic            w_hs;
  logic            rsp_fire;
  logic            rsp_err_d;
  logic [DW-1:0]   rsp_data_d;

  assign timeout = (cnt_q == CW'(TIMEOUT_P - 1));
  assign in_wait = (state_q == WR_ADDR) || (state_q == WR_RESP) ||
                   (state_q == RD_ADDR) || (state_q == RD_DATA);
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;

  // Round-robin pick; no accept while a response pulse is out
  always_comb begin
    gnt_idx = 1'b0;
    unique case (req_valid)
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last_grant_q;
      default: gnt_idx = 1'b0;
    endcase
    gnt_vld   = (state_q == IDLE) && (|req_valid) && !(|rsp_valid_q);
    req_ready = gnt_vld ? (2'b01 << gnt_idx) : 2'b00;
  end

  // Next state and response decode
  always_comb begin
    state_d    = state_q;
    rsp_fire   = 1'b0;
    rsp_err_d  = 1'b0;
    rsp_data_d = '0;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) state_d = GRANT;
      end
      GRANT: begin
        state_d = write_q ? WR_ADDR : RD_ADDR;
      end
      WR_ADDR: begin
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d = WR_RESP;
        end else if (timeout) begin
          state_d   = IDLE;
          rsp_fire  = 1'b1;
          rsp_err_d = 1'b1;
        end
      end
      WR_RESP: begin
        if (bvalid) begin
          state_d   = IDLE;
          rsp_fire  = 1'b1;
          rsp_err_d = |bresp;
        end else if (timeout) begin
          state_d   = IDLE;
          rsp_fire  = 1'b1;
          rsp_err_d = 1'b1;
        end
      end
      RD_ADDR: begin
        if (arready) begin
          state_d = RD_DATA;
        end else if (timeout) begin
          state_d   = IDLE;
          rsp_fire  = 1'b1;
          rsp_err_d = 1'b1;
        end
      end
      RD_DATA: begin
        if (rvalid) begin
          state_d    = IDLE;
          rsp_fire   = 1'b1;
          rsp_err_d  = |rresp;
          rsp_data_d = rdata;
        end else if (timeout) begin
          state_d   = IDLE;
          rsp_fire  = 1'b1;
          rsp_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, captured command, wait counter and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      idx_q        <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      cnt_q        <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      rsp_valid_q  <= 2'b00;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (gnt_vld) begin
        idx_q        <= gnt_idx;
        last_grant_q <= gnt_idx;
        write_q      <= req_write[gnt_idx];
        addr_q       <= gnt_idx ? req_addr[AW +: AW] : req_addr[0 +: AW];
        wdata_q      <= gnt_idx ? req_wdata[DW +: DW] : req_wdata[0 +: DW];
        wstrb_q      <= gnt_idx ? req_wstrb[SW +: SW] : req_wstrb[0 +: SW];
      end
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (in_wait) begin
        cnt_q <= cnt_q + 1'b1;
      end
      aw_done_q   <= (state_d == WR_ADDR) && (aw_done_q || aw_hs);
      w_done_q    <= (state_d == WR_ADDR) && (w_done_q || w_hs);
      rsp_valid_q <= rsp_fire ? (2'b01 << idx_q) : 2'b00;
      rsp_rdata_q <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  assign awaddr  = addr_q;
  assign araddr  = addr_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign awvalid = (state_q == WR_ADDR) && !aw_done_q;
  assign wvalid  = (state_q == WR_ADDR) && !w_done_q;
  assign arvalid = (state_q == RD_ADDR);
  assign bready  = (state_q == IDLE) || (state_q == WR_RESP);
  assign rready  = (state_q == IDLE) || (state_q == RD_DATA);

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter against a small register-bank slave.
// Slave answers with one-cycle registered ready and response.
module tb_reg_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_write;
  logic [13:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [6:0]  awaddr;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0;
  logic        bready;
  logic [6:0]  araddr;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = 2'b00;
  logic        rvalid = 1'b0;
  logic        rready;

  logic        hang_aw = 1'b0;
  logic [1:0]  rresp_cfg = 2'b00;
  logic        use_ovr = 1'b0;
  logic [31:0] ovr_data = '0;
  logic [31:0] cr_led_0 = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  reg_bus_arbiter #(
    .AXI_DATA_WIDTH_P(32),
    .AXI_ADDR_WIDTH_P(7),
    .TIMEOUT_P(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid),
    .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
    .rready(rready)
  );

  // Register-bank style slave; cr_led_0 lives at address 0
  always @(posedge clk) begin
    if (hang_aw) begin
      awready <= 1'b0;
      wready  <= 1'b0;
    end else begin
      awready <= awvalid && wvalid && !awready;
      wready  <= awvalid && wvalid && !wready;
    end
    if (awvalid && awready && wvalid && wready) begin
      if (awaddr[6:2] == 5'd0) begin
        for (int b = 0; b < 4; b++)
          if (wstrb[b]) cr_led_0[8*b +: 8] <= wdata[8*b +: 8];
      end
      bvalid <= 1'b1;
      bresp  <= 2'b00;
    end else if (bvalid && bready) begin
      bvalid <= 1'b0;
    end
    arready <= arvalid && !arready;
    if (arvalid && arready) begin
      rvalid <= 1'b1;
      rresp  <= rresp_cfg;
      if (use_ovr) rdata <= ovr_data;
      else rdata <= (araddr[6:2] == 5'd0) ? cr_led_0 : 32'd0;
    end else if (rvalid && rready) begin
      rvalid <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command and wait (bounded) for its response pulse
  task automatic do_cmd(
    input  int          i,
    input  logic        wr,
    input  logic [6:0]  a,
    input  logic [31:0] d,
    input  logic [3:0]  s,
    output int          lat,
    output logic [1:0]  rv,
    output logic [31:0] rd,
    output logic        er
  );
    bit acc;
    acc = 1'b0;
    lat = -1;
    rv  = 2'b00;
    rd  = '0;
    er  = 1'b0;
    req_valid[i]       = 1'b1;
    req_write[i]       = wr;
    req_addr[i*7 +: 7] = a;
    req_wdata[i*32 +: 32] = d;
    req_wstrb[i*4 +: 4]   = s;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        acc = 1'b1;
        break;
      end
      tick();
    end
    tick();
    req_valid[i] = 1'b0;
    if (acc) begin
      for (int k = 1; k <= 40; k++) begin
        @(negedge clk);
        if (rsp_valid !== 2'b00) begin
          lat = k;
          rv  = rsp_valid;
          rd  = rsp_rdata;
          er  = rsp_err;
          break;
        end
        tick();
      end
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 2'b00;
    req_write = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;
    tick();
    tick();
    @(negedge clk);
    tests++;
    if ({req_ready, rsp_valid, rsp_err} !== 5'b0) begin
      fails++;
      $display("FAIL rst_rsp: got %b exp 00000",
               {req_ready, rsp_valid, rsp_err});
    end
    tests++;
    if ({awvalid, wvalid, arvalid, bready, rready} !== 5'b00011) begin
      fails++;
      $display("FAIL rst_axi_ctl: got %b exp 00011",
               {awvalid, wvalid, arvalid, bready, rready});
    end
    tests++;
    if ({awaddr, araddr, wdata, wstrb, rsp_rdata} !== '0) begin
      fails++;
      $display("FAIL rst_data: awaddr %h wdata %h rdata %h exp 0",
               awaddr, wdata, rsp_rdata);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    int   lat;
    bit   seen;
    req_valid[0]   = 1'b1;
    req_write[0]   = 1'b1;
    req_addr[6:0]  = 7'h00;
    req_wdata[31:0] = 32'h0000_00A5;
    req_wstrb[3:0] = 4'hF;
    @(negedge clk);
    tests++;
    if (req_ready !== 2'b01) begin
      fails++;
      $display("FAIL wr_accept: got %b exp 01", req_ready);
    end
    tick();
    req_valid[0] = 1'b0;
    @(negedge clk);
    tests++;
    if ({awvalid, wvalid} !== 2'b00) begin
      fails++;
      $display("FAIL wr_n1_valid: got %b exp 00", {awvalid, wvalid});
    end
    tick();
    @(negedge clk);
    tests++;
    if ({awvalid, wvalid, awaddr, wdata} !== {2'b11, 7'h00, 32'hA5}) begin
      fails++;
      $display("FAIL wr_n2_valid: aw %b w %b addr %h data %h exp 1 1 00 a5",
               awvalid, wvalid, awaddr, wdata);
    end
    tick();
    tick();
    @(negedge clk);
    tests++;
    if (rsp_valid !== 2'b00) begin
      fails++;
      $display("FAIL wr_n4_rsp: got %b exp 00", rsp_valid);
    end
    tick();
    req_valid[1] = 1'b1;
    req_write[1] = 1'b0;
    req_addr[13:7] = 7'h00;
    @(negedge clk);
    tests++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b01, 1'b0, 32'd0}) begin
      fails++;
      $display("FAIL wr_n5_rsp: valid %b err %b rdata %h exp 01 0 0",
               rsp_valid, rsp_err, rsp_rdata);
    end
    tests++;
    if (req_ready !== 2'b00) begin
      fails++;
      $display("FAIL accept_during_rsp: got %b exp 00", req_ready);
    end
    tests++;
    if (cr_led_0 !== 32'h0000_00A5) begin
      fails++;
      $display("FAIL wr_slave_reg: got %h exp 000000a5", cr_led_0);
    end
    tick();
    @(negedge clk);
    tests++;
    if (req_ready !== 2'b10) begin
      fails++;
      $display("FAIL accept_after_rsp: got %b exp 10", req_ready);
    end
    tick();
    req_valid[1] = 1'b0;
    lat  = 0;
    seen = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (rsp_valid !== 2'b00) begin
        seen = 1'b1;
        lat  = k;
        break;
      end
      tick();
    end
    tests++;
    if (!seen || lat != 5 || rsp_valid !== 2'b10 ||
        rsp_rdata !== 32'hA5) begin
      fails++;
      $display("FAIL rd_after_wr: lat %0d valid %b rdata %h exp 5 10 a5",
               lat, rsp_valid, rsp_rdata);
    end
    tick();
  endtask

  task automatic test_single_read();
    int lat;
    logic [1:0] rv;
    logic [31:0] rd;
    logic er;
    use_ovr  = 1'b1;
    ovr_data = 32'h0102_0304;
    do_cmd(1, 1'b0, 7'h00, 32'd0, 4'h0, lat, rv, rd, er);
    tests++;
    if (lat != 5 || rv !== 2'b10 || rd !== 32'h0102_0304 || er !== 1'b0) begin
      fails++;
      $display("FAIL rd_single: lat %0d valid %b rdata %h err %b exp 5 10 01020304 0",
               lat, rv, rd, er);
    end
  endtask

  task automatic test_rresp_err();
    int lat;
    logic [1:0] rv;
    logic [31:0] rd;
    logic er;
    rresp_cfg = 2'b10;
    do_cmd(0, 1'b0, 7'h00, 32'd0, 4'h0, lat, rv, rd, er);
    tests++;
    if (lat != 5 || rv !== 2'b01 || rd !== 32'h0102_0304 || er !== 1'b1) begin
      fails++;
      $display("FAIL rd_slverr: lat %0d valid %b rdata %h err %b exp 5 01 01020304 1",
               lat, rv, rd, er);
    end
    rresp_cfg = 2'b00;
  endtask

  task automatic test_timeout();
    int lat;
    int hi;
    logic [1:0] rv;
    logic [31:0] rd;
    logic er;
    hang_aw = 1'b1;
    lat = -1;
    hi  = 0;
    rv  = 2'b00;
    er  = 1'b0;
    rd  = '1;
    req_valid[0]    = 1'b1;
    req_write[0]    = 1'b1;
    req_addr[6:0]   = 7'h00;
    req_wdata[31:0] = 32'hDEAD_BEEF;
    req_wstrb[3:0]  = 4'hF;
    @(negedge clk);
    tests++;
    if (req_ready !== 2'b01) begin
      fails++;
      $display("FAIL to_accept: got %b exp 01", req_ready);
    end
    tick();
    req_valid[0] = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (awvalid && wvalid) hi++;
      if (rsp_valid !== 2'b00) begin
        lat = k;
        rv  = rsp_valid;
        er  = rsp_err;
        rd  = rsp_rdata;
        break;
      end
      tick();
    end
    tests++;
    if (hi != 8 || lat != 10) begin
      fails++;
      $display("FAIL to_wait: valid cycles %0d rsp at %0d exp 8 10", hi, lat);
    end
    tests++;
    if (rv !== 2'b01 || er !== 1'b1 || rd !== 32'd0 ||
        {awvalid, wvalid} !== 2'b00) begin
      fails++;
      $display("FAIL to_rsp: valid %b err %b rdata %h aw/w %b exp 01 1 0 00",
               rv, er, rd, {awvalid, wvalid});
    end
    tick();
    hang_aw = 1'b0;
    do_cmd(1, 1'b0, 7'h00, 32'd0, 4'h0, lat, rv, rd, er);
    tests++;
    if (lat != 5 || rv !== 2'b10 || er !== 1'b0 || rd !== 32'h0102_0304) begin
      fails++;
      $display("FAIL to_recover: lat %0d valid %b err %b rdata %h exp 5 10 0 01020304",
               lat, rv, er, rd);
    end
  endtask

  task automatic test_back_to_back();
    int order[8];
    int acc[8];
    int rem[2];
    int ng;
    int r0;
    int r1;
    int ovl;
    int alt_bad;
    int gap_bad;
    int gi;
    bit gnt;
    ng = 0; r0 = 0; r1 = 0; ovl = 0; gi = 0;
    rem[0] = 4;
    rem[1] = 4;
    req_write       = 2'b01;
    req_addr        = '0;
    req_wdata[31:0] = 32'h0000_0011;
    req_wstrb[3:0]  = 4'h1;
    req_valid       = 2'b11;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      gnt = 1'b0;
      if (req_ready !== 2'b00) begin
        gnt = 1'b1;
        gi  = req_ready[1] ? 1 : 0;
        if (ng < 8) begin
          order[ng] = gi;
          acc[ng]   = cyc;
        end
        ng++;
        if (rsp_valid !== 2'b00) ovl++;
      end
      if (rsp_valid[0]) r0++;
      if (rsp_valid[1]) r1++;
      if (r0 + r1 >= 8) break;
      tick();
      if (gnt) begin
        rem[gi]--;
        if (rem[gi] <= 0) req_valid[gi] = 1'b0;
      end
    end
    req_valid = 2'b00;
    alt_bad = 0;
    gap_bad = 0;
    for (int j = 0; j < 8 && j < ng; j++) begin
      if (order[j] != j % 2) alt_bad++;
      if (j > 0 && acc[j] - acc[j-1] != 6) gap_bad++;
    end
    tests++;
    if (ng != 8 || alt_bad != 0) begin
      fails++;
      $display("FAIL b2b_order: grants %0d out-of-turn %0d exp 8 0", ng, alt_bad);
    end
    tests++;
    if (r0 != 4 || r1 != 4) begin
      fails++;
      $display("FAIL b2b_rsp_count: req0 %0d req1 %0d exp 4 4", r0, r1);
    end
    tests++;
    if (gap_bad != 0 || ovl != 0) begin
      fails++;
      $display("FAIL b2b_spacing: bad gaps %0d accept-with-rsp %0d exp 0 0",
               gap_bad, ovl);
    end
    tick();
    tick();
  endtask

  task automatic test_reset_in_wr_resp();
    int lat;
    int stray;
    logic [1:0] rv;
    logic [31:0] rd;
    logic er;
    stray = 0;
    req_valid[0]    = 1'b1;
    req_write[0]    = 1'b1;
    req_addr[6:0]   = 7'h00;
    req_wdata[31:0] = 32'h0000_005A;
    req_wstrb[3:0]  = 4'hF;
    @(negedge clk);
    tests++;
    if (req_ready !== 2'b01) begin
      fails++;
      $display("FAIL rstmid_accept: got %b exp 01", req_ready);
    end
    tick();
    req_valid[0] = 1'b0;
    tick();
    tick();
    tick();
    @(negedge clk);
    tests++;
    if ({bvalid, bready, awvalid, wvalid} !== 4'b1100) begin
      fails++;
      $display("FAIL rstmid_in_wr_resp: bvalid/bready/aw/w %b exp 1100",
               {bvalid, bready, awvalid, wvalid});
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({req_ready, rsp_valid, rsp_err, awvalid, wvalid, arvalid,
         bready, rready} !== 10'b00_00_0_000_11 ||
        {awaddr, wdata, wstrb, rsp_rdata} !== '0) begin
      fails++;
      $display("FAIL rstmid_outputs: ctl %b awaddr %h wdata %h exp 0000000011 0 0",
               {req_ready, rsp_valid, rsp_err, awvalid, wvalid, arvalid,
                bready, rready}, awaddr, wdata);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      if (rsp_valid !== 2'b00) stray++;
    end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    if (rsp_valid !== 2'b00) stray++;
    tests++;
    if (stray != 0) begin
      fails++;
      $display("FAIL rstmid_no_rsp: stray pulses %0d exp 0", stray);
    end
    tick();
    do_cmd(1, 1'b1, 7'h00, 32'h0000_0077, 4'h1, lat, rv, rd, er);
    tests++;
    if (lat != 5 || rv !== 2'b10 || er !== 1'b0 || cr_led_0[7:0] !== 8'h77) begin
      fails++;
      $display("FAIL rstmid_fresh_wr: lat %0d valid %b err %b reg %h exp 5 10 0 77",
               lat, rv, er, cr_led_0[7:0]);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_rresp_err();
    test_timeout();
    test_back_to_back();
    test_reset_in_wr_resp();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
